// File: rtl/hsaf_mon_pkg.sv
// hsaf_mon_pkg: shared FSM encodings and counter width for the error monitors
package hsaf_mon_pkg;
  localparam int CNT_W = 16;
  localparam logic [1:0] WARMUP    = 2'd0;
  localparam logic [1:0] TRACKING  = 2'd1;
  localparam logic [1:0] CONVERGED = 2'd2;
  localparam logic [1:0] DIVERGED  = 2'd3;
endpackage

// File: rtl/mse_monitor_err_square.sv
// err_square: registered square of a signed Q-format error, rounded and saturated
module err_square #(
  parameter int WIDTH = 16,
  parameter int QP    = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] err_in,
  input  logic             err_valid,
  output logic [WIDTH-1:0] sq,
  output logic             sq_valid
);
  localparam logic [2*WIDTH:0] RND = (2*WIDTH+1)'(1) << (QP - 1);
  logic signed [2*WIDTH-1:0] prod;
  logic [2*WIDTH:0] rnd, shf;
  logic [WIDTH-1:0] sq_d;
  always_comb begin
    prod = $signed(err_in) * $signed(err_in);
    rnd = {1'b0, prod} + RND;
    shf = rnd >> QP;
    sq_d = |shf[2*WIDTH:WIDTH] ? '1 : shf[WIDTH-1:0];
  end
  // clear drops the sample being captured so it never reaches the average
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sq <= '0;
      sq_valid <= 1'b0;
    end else begin
      sq <= sq_d;
      sq_valid <= err_valid & ~clear;
    end
endmodule

// File: rtl/mse_monitor.sv
// mse_monitor: EMA of squared filter error with warmup/tracking/converged/diverged FSM
// optional MSE_MON_PEAK_EN adds a peak |err_in| tracker on peak_err
module mse_monitor
  import hsaf_mon_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int QP         = 12,
  parameter int AVG_SHIFT  = 4,
  parameter int WARMUP_LEN = 8,
  parameter int HOLD_LEN   = 4,
  parameter int CONV_THR   = 16,
  parameter int DIV_THR    = 16'h4000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] err_in,
  input  logic             err_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] mse_out,
  output logic [1:0]       state_out,
  output logic             converged,
  output logic             diverged,
  output logic [CNT_W-1:0] conv_count,
  output logic [WIDTH-1:0] peak_err
);
  localparam int AW = WIDTH + AVG_SHIFT;
  localparam logic [WIDTH-1:0] CT = WIDTH'(CONV_THR);
  localparam logic [WIDTH-1:0] DT = WIDTH'(DIV_THR);
  localparam logic [CNT_W-1:0] WL = CNT_W'(WARMUP_LEN);
  localparam logic [CNT_W-1:0] HL = CNT_W'(HOLD_LEN);
  logic [WIDTH-1:0] sq, mse_n;
  logic sq_valid;
  logic [AW-1:0] acc, acc_n;
  logic [AW:0] sum;
  logic [CNT_W-1:0] sample_cnt, cnt_n, hold_cnt, hold_n;
  logic [1:0] state, state_n;
  err_square #(.WIDTH(WIDTH), .QP(QP)) u_sq (
    .clk(clk), .reset(reset), .clear(clear), .err_in(err_in),
    .err_valid(err_valid), .sq(sq), .sq_valid(sq_valid)
  );
  // all transitions are judged on the post-update average and count
  always_comb begin
    sum = {1'b0, acc - (acc >> AVG_SHIFT)} + {{(AVG_SHIFT+1){1'b0}}, sq};
    acc_n = sum[AW] ? '1 : sum[AW-1:0];
    mse_n = acc_n[AW-1:AVG_SHIFT];
    cnt_n = &sample_cnt ? sample_cnt : sample_cnt + 1'b1;
    hold_n = mse_n < CT ? hold_cnt + 1'b1 : '0;
    state_n = (state != DIVERGED && mse_n > DT) ? DIVERGED :
              state == WARMUP    ? (cnt_n >= WL ? TRACKING : WARMUP) :
              state == TRACKING  ? (hold_n == HL ? CONVERGED : TRACKING) :
              state == CONVERGED ? (mse_n >= CT ? TRACKING : CONVERGED) : DIVERGED;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc <= '0;
      sample_cnt <= '0;
      hold_cnt <= '0;
      conv_count <= '0;
      state <= WARMUP;
    end else if (clear) begin
      acc <= '0;
      sample_cnt <= '0;
      hold_cnt <= '0;
      conv_count <= '0;
      state <= WARMUP;
    end else if (sq_valid) begin
      acc <= acc_n;
      sample_cnt <= cnt_n;
      hold_cnt <= (state == TRACKING && state_n == TRACKING) ? hold_n : '0;
      conv_count <= (state == TRACKING && state_n == CONVERGED) ? cnt_n : conv_count;
      state <= state_n;
    end
  assign mse_out = acc[AW-1:AVG_SHIFT];
  assign state_out = state;
  assign converged = state == CONVERGED;
  assign diverged = state == DIVERGED;
`ifdef MSE_MON_PEAK_EN
  logic [WIDTH-1:0] mag, peak;
  // the most negative input has no positive twin, so it pins to the max
  always_comb
    mag = !err_in[WIDTH-1] ? err_in :
          err_in[WIDTH-2:0] == '0 ? {1'b0, {(WIDTH-1){1'b1}}} : -err_in;
  always_ff @(posedge clk or posedge reset)
    if (reset) peak <= '0;
    else if (clear) peak <= '0;
    else if (err_valid && mag > peak) peak <= mag;
  assign peak_err = peak;
`else
  assign peak_err = '0;
`endif
endmodule
